tuart_tx_fifo: RTL and testbench

Parametrised, buffered UART transmitter: the next generation of the fixed-format `tuart_tx`. It adds a configurable word width, runtime baud divider, optional even/odd parity, one or two stop bits, an internal FIFO and frame-boundary XOFF flow control. It sits between the core's readout path (valid/ready producer) and the serial pin, with `xoff_i` driven from the `FlowCtr` interface.

---
 rtl/tuart_tx_fifo.sv | 204 ++++++++++++++++++++
 tb/tb_tuart_tx_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tuart_tx_fifo.sv
// Buffered UART transmitter: FIFO in front of a start/data/parity/stop serialiser
// with per-frame configuration latching and frame-boundary XOFF.
module tuart_tx_fifo #(
  parameter int WORD_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_in,
  input  logic [WORD_BITS-1:0]          data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [DIV_WIDTH-1:0]          div_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          two_stop_i,
  input  logic                          xoff_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(WORD_BITS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_bit(input logic [WORD_BITS-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

  logic [WORD_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]        level_r, level_nxt_s;
  logic                 ready_r;
  logic                 push_s, pop_s, start_ok_s, bit_end_s;

  state_t               state_r, state_nxt_s;
  logic                 tx_r, tx_nxt_s, busy_r;
  logic [DIV_WIDTH-1:0] cnt_r, cnt_nxt_s, div_r;
  logic [WORD_BITS-1:0] shift_r, shift_nxt_s;
  logic [BW-1:0]        bit_cnt_r, bit_cnt_nxt_s;
  logic                 stop2_r, stop2_nxt_s;
  logic                 par_en_r, par_r, two_stop_r;

  assign push_s      = valid_i && ready_r;
  assign start_ok_s  = (level_r != LW'(0)) && !xoff_i;
  assign bit_end_s   = (cnt_r == DIV_WIDTH'(0));
  assign level_nxt_s = level_r + LW'(push_s) - LW'(pop_s);

  // FIFO storage write port
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  // FIFO pointers and registered status
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      ready_r  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      level_r <= level_nxt_s;
      ready_r <= (level_nxt_s != LW'(FIFO_DEPTH));
    end
  end

  // Serialiser next-state, next-bit and pop decision
  always_comb begin
    state_nxt_s   = state_r;
    tx_nxt_s      = tx_r;
    cnt_nxt_s     = bit_end_s ? div_r : (cnt_r - DIV_WIDTH'(1));
    shift_nxt_s   = shift_r;
    bit_cnt_nxt_s = bit_cnt_r;
    stop2_nxt_s   = stop2_r;
    pop_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tx_nxt_s = 1'b1;
        if (start_ok_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_START;
          tx_nxt_s    = 1'b0;
          cnt_nxt_s   = div_i;
          shift_nxt_s = mem_r[rd_ptr_r];
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_nxt_s   = ST_DATA;
          tx_nxt_s      = shift_r[0];
          shift_nxt_s   = {1'b0, shift_r[WORD_BITS-1:1]};
          bit_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          if (bit_cnt_r == BW'(WORD_BITS - 1)) begin
            if (par_en_r) begin
              state_nxt_s = ST_PARITY;
              tx_nxt_s    = par_r;
            end else begin
              state_nxt_s = ST_STOP;
              tx_nxt_s    = 1'b1;
              stop2_nxt_s = 1'b0;
            end
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + BW'(1);
            tx_nxt_s      = shift_r[0];
            shift_nxt_s   = {1'b0, shift_r[WORD_BITS-1:1]};
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_nxt_s = ST_STOP;
          tx_nxt_s    = 1'b1;
          stop2_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          // The second stop bit reuses this state; the next frame may follow with no gap.
          if (two_stop_r && !stop2_r) begin
            stop2_nxt_s = 1'b1;
            tx_nxt_s    = 1'b1;
          end else if (start_ok_s) begin
            pop_s       = 1'b1;
            state_nxt_s = ST_START;
            tx_nxt_s    = 1'b0;
            cnt_nxt_s   = div_i;
            shift_nxt_s = mem_r[rd_ptr_r];
          end else begin
            state_nxt_s = ST_IDLE;
            tx_nxt_s    = 1'b1;
          end
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        tx_nxt_s    = 1'b1;
      end
    endcase
  end

  // Serialiser state, line output and per-frame configuration
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state_r    <= ST_IDLE;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      cnt_r      <= '0;
      shift_r    <= '0;
      bit_cnt_r  <= '0;
      stop2_r    <= 1'b0;
      div_r      <= '0;
      par_en_r   <= 1'b0;
      par_r      <= 1'b0;
      two_stop_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      tx_r      <= tx_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
      cnt_r     <= cnt_nxt_s;
      shift_r   <= shift_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      stop2_r   <= stop2_nxt_s;
      if (pop_s) begin
        div_r      <= div_i;
        par_en_r   <= parity_en_i;
        par_r      <= parity_bit(mem_r[rd_ptr_r], parity_odd_i);
        two_stop_r <= two_stop_i;
      end
    end
  end

  assign ready_o = ready_r;
  assign level_o = level_r;
  assign tx_o    = tx_r;
  assign busy_o  = busy_r;

endmodule

// File: tb/tb_tuart_tx_fifo.sv
// Directed and randomized bench for tuart_tx_fifo; expected line waveforms are
// built per frame from the word and configuration, cycle by cycle.
module tb_tuart_tx_fifo;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int DW = 16;
  localparam int LW = $clog2(D) + 1;

  logic          clk_i = 1'b0;
  logic          rst_in;
  logic [W-1:0]  data_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] div_i;
  logic          parity_en_i, parity_odd_i, two_stop_i, xoff_i;
  logic          tx_o, busy_o;
  logic [LW-1:0] level_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  tuart_tx_fifo #(.WORD_BITS(W), .FIFO_DEPTH(D), .DIV_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_in(rst_in), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .div_i(div_i), .parity_en_i(parity_en_i),
    .parity_odd_i(parity_odd_i), .two_stop_i(two_stop_i), .xoff_i(xoff_i),
    .tx_o(tx_o), .busy_o(busy_o), .level_o(level_o)
  );

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] w);
    data_i  = w;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic set_cfg(input int dv, input logic pe, input logic po, input logic ts);
    div_i        = DW'(dv);
    parity_en_i  = pe;
    parity_odd_i = po;
    two_stop_i   = ts;
  endtask

  // Bit k of the frame at index k: start, data LSB first, optional parity, then stop ones.
  function automatic logic [15:0] frame_bits(input logic [W-1:0] w, input logic pe, input logic po);
    logic [15:0] b;
    b    = '1;
    b[0] = 1'b0;
    for (int i = 0; i < W; i++) b[1+i] = w[i];
    if (pe) b[1+W] = (^w) ^ po;
    return b;
  endfunction

  // Check every cycle of a frame from cycle 'skip' (0 = first cycle tx_o is low) to its end.
  task automatic expect_frame(input string tag, input logic [W-1:0] w, input int dv,
                              input logic pe, input logic po, input logic ts, input int skip);
    logic [15:0] bits;
    int          len;
    bits = frame_bits(w, pe, po);
    len  = 1 + W + int'(pe) + (ts ? 2 : 1);
    chk({tag, "_busy"}, busy_o, 1);
    for (int j = skip; j < len * (dv + 1); j++) begin
      chk(tag, tx_o, bits[j/(dv+1)]);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] q[$];
    logic [W-1:0] w;
    int           n, dv;
    logic         pe, po, ts;

    rst_in = 1'b0; valid_i = 1'b0; data_i = '0; xoff_i = 1'b0;
    set_cfg(0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_tx", tx_o, 1); chk("rst_busy", busy_o, 0);
    chk("rst_ready", ready_o, 1); chk("rst_level", level_o, 0);
    rst_in = 1'b1;
    tick();

    // Basic frame and first-word latency
    set_cfg(3, 1'b0, 1'b0, 1'b0);
    push(8'h55);
    chk("lat_level1", level_o, 1);
    tick();
    chk("lat_tx", tx_o, 0); chk("lat_busy", busy_o, 1); chk("lat_level0", level_o, 0);
    expect_frame("basic", 8'h55, 3, 1'b0, 1'b0, 1'b0, 0);
    chk("basic_busy_end", busy_o, 0); chk("basic_idle_tx", tx_o, 1);

    // Parity and two stop bits, even then odd
    set_cfg(0, 1'b1, 1'b0, 1'b1);
    push(8'h07); tick();
    expect_frame("par_even", 8'h07, 0, 1'b1, 1'b0, 1'b1, 0);
    chk("par_even_end", busy_o, 0);
    set_cfg(0, 1'b1, 1'b1, 1'b1);
    push(8'h07); tick();
    expect_frame("par_odd", 8'h07, 0, 1'b1, 1'b1, 1'b1, 0);
    chk("par_odd_end", busy_o, 0);

    // FIFO full with back-to-back frames
    set_cfg(0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      data_i  = W'(8'hA0 + i);
      valid_i = 1'b1;
      chk("full_ready", ready_o, (i < 9) ? 1 : 0);
      tick();
      chk("full_level", level_o, (i == 0) ? 1 : ((i > 8) ? 8 : i));
    end
    valid_i = 1'b0;
    expect_frame("b2b_0", 8'hA0, 0, 1'b0, 1'b0, 1'b0, 8);
    for (int i = 1; i < 9; i++) expect_frame("b2b", W'(8'hA0 + i), 0, 1'b0, 1'b0, 1'b0, 0);
    chk("b2b_end_busy", busy_o, 0); chk("b2b_end_level", level_o, 0);
    chk("b2b_end_tx", tx_o, 1);

    // XOFF raised mid-frame with three words queued
    set_cfg(1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push(W'(8'hB0 + i));
    chk("xoff_level_pre", level_o, 3);
    xoff_i = 1'b1;
    expect_frame("xoff_cur", 8'hB0, 1, 1'b0, 1'b0, 1'b0, 2);
    for (int i = 0; i < 8; i++) begin
      chk("xoff_tx", tx_o, 1); chk("xoff_level", level_o, 3); chk("xoff_busy", busy_o, 0);
      tick();
    end
    xoff_i = 1'b0;
    tick();
    chk("xon_start", tx_o, 0);
    for (int i = 1; i < 4; i++) expect_frame("xon", W'(8'hB0 + i), 1, 1'b0, 1'b0, 1'b0, 0);
    chk("xon_end_level", level_o, 0);

    // Reset during DATA with four words queued
    for (int i = 0; i < 5; i++) push(W'(8'hC0 + i));
    repeat (6) tick();
    chk("mrst_pre_level", level_o, 4);
    rst_in = 1'b0;
    tick();
    chk("mrst_tx", tx_o, 1); chk("mrst_level", level_o, 0);
    chk("mrst_busy", busy_o, 0); chk("mrst_ready", ready_o, 1);
    rst_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("mrst_quiet", {tx_o, busy_o}, 2'b10);
    end
    push(8'hD5); tick();
    expect_frame("mrst_new", 8'hD5, 1, 1'b0, 1'b0, 1'b0, 0);
    chk("mrst_new_end", busy_o, 0);

    // Divider changed mid-frame applies only to the next frame
    set_cfg(3, 1'b0, 1'b0, 1'b0);
    push(8'hE1); tick();
    chk("cfg_start", tx_o, 0);
    tick(); tick();
    div_i = DW'(1);
    push(8'hE2);
    expect_frame("cfg_old", 8'hE1, 3, 1'b0, 1'b0, 1'b0, 3);
    expect_frame("cfg_new", 8'hE2, 1, 1'b0, 1'b0, 1'b0, 0);
    chk("cfg_end", busy_o, 0);

    // Randomized bursts against the frame model
    for (int it = 0; it < 12; it++) begin
      dv = int'($urandom_range(0, 3));
      pe = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      ts = 1'($urandom_range(0, 1));
      n  = int'($urandom_range(1, 3));
      set_cfg(dv, pe, po, ts);
      for (int i = 0; i < n; i++) begin
        w = W'($urandom);
        q.push_back(w);
        push(w);
      end
      chk("rnd_level", level_o, (n == 1) ? 1 : n - 1);
      if (n == 1) tick();
      expect_frame("rnd_first", q.pop_front(), dv, pe, po, ts, (n == 1) ? 0 : n - 2);
      while (q.size() > 0) expect_frame("rnd_next", q.pop_front(), dv, pe, po, ts, 0);
      chk("rnd_idle", {tx_o, busy_o}, 2'b10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
